// File: rtl/fifo_bank_drain_pkg.sv
// fifo_bank_drain_pkg
// Shared types and helpers for the FIFO bank drain stage and the bank itself.
// The flow_id_t/elem_t typedefs are sized for the default configuration
// (16 flows, 8-bit data). Modules built with other parameters declare local
// types of the same shape from their own parameters.
// Optional feature macro used by the drain stage: FIFO_BANK_DRAIN_STATS_EN.

package fifo_bank_drain_pkg;

    localparam int unsigned DefNumFlows  = 16;
    localparam int unsigned DefDataWidth = 8;

    // Flow-id width, shared with fifo_bank. One extra code point is kept so
    // that NUM_FLOWS itself is representable.
    function automatic int unsigned idx_width(input int unsigned num_flows);
        return $clog2(num_flows + 1);
    endfunction

    localparam int unsigned DefIdxWidth = idx_width(DefNumFlows);

    typedef logic [DefIdxWidth-1:0] flow_id_t;

    typedef struct packed {
        flow_id_t                flow_id;
        logic [DefDataWidth-1:0] data;
    } elem_t;

    // Per-cycle use of the shared pop/reinsert port.
    typedef enum logic [1:0] {
        ModeScan,
        ModeReinsert,
        ModeBlocked
    } mode_e;

endpackage

// File: rtl/fifo_bank_drain_rr_ptr.sv
// fifo_bank_drain_rr_ptr
// Round-robin flow pointer: counts 0..NUM_FLOWS-1 and wraps, advancing only
// when advance_i is set, holding otherwise.
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset (pointer returns to 0)
//   advance_i  step the pointer this cycle
//   ptr_o      current pointer value

module fifo_bank_drain_rr_ptr #(
    parameter int unsigned NUM_FLOWS = 16,
    parameter int unsigned IDX_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 advance_i,
    output logic [IDX_WIDTH-1:0] ptr_o
);

    localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_FLOWS - 1);

    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (ptr_q == LastIdx) ? '0 : ptr_q + IDX_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_bank_drain.sv
// fifo_bank_drain
// Downstream scheduler stage for the per-flow FIFO bank. Scans flows
// round-robin through the bank's single pop port, hands each dequeued head to
// the PIFO on a registered valid/ready output, and writes PIFO evictions back
// into the bank through the reinsert path on the same port.
// Optional feature: define FIFO_BANK_DRAIN_STATS_EN to add saturating 32-bit
// dequeue/reinsert counters with a synchronous clear.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   o__pop_flow_id, o__pop          bank pop/reinsert flow and dequeue strobe
//   i__pop_valid, i__pop_data       bank head for o__pop_flow_id (same cycle)
//   o__reinsert_valid/_data         write evicted element back to the bank
//   i__bank_push_valid/_flow_id     snooped ingress push
//   i__flow_eligible                per-flow dequeue permission
//   o__out_valid/_flow_id/_data     element to PIFO; i__out_ready accepts
//   i__evict_valid/_flow_id/_data   element returned by PIFO; o__evict_ready
//   i__stat_clear, o__stat_*        statistics (FIFO_BANK_DRAIN_STATS_EN only)

module fifo_bank_drain
    import fifo_bank_drain_pkg::*;
#(
    parameter  int unsigned NUM_FLOWS  = 16,
    parameter  int unsigned DATA_WIDTH = 8,
    localparam int unsigned IDX_WIDTH  = idx_width(NUM_FLOWS)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [IDX_WIDTH-1:0]  o__pop_flow_id,
    output logic                  o__pop,
    input  logic                  i__pop_valid,
    input  logic [DATA_WIDTH-1:0] i__pop_data,
    output logic                  o__reinsert_valid,
    output logic [DATA_WIDTH-1:0] o__reinsert_data,
    input  logic                  i__bank_push_valid,
    input  logic [IDX_WIDTH-1:0]  i__bank_push_flow_id,
    input  logic [NUM_FLOWS-1:0]  i__flow_eligible,
    output logic                  o__out_valid,
    output logic [IDX_WIDTH-1:0]  o__out_flow_id,
    output logic [DATA_WIDTH-1:0] o__out_data,
    input  logic                  i__out_ready,
    input  logic                  i__evict_valid,
    input  logic [IDX_WIDTH-1:0]  i__evict_flow_id,
    input  logic [DATA_WIDTH-1:0] i__evict_data,
    output logic                  o__evict_ready
`ifdef FIFO_BANK_DRAIN_STATS_EN
    ,
    input  logic                  i__stat_clear,
    output logic [31:0]           o__stat_dequeued,
    output logic [31:0]           o__stat_reinserted
`endif
);

    typedef logic [IDX_WIDTH-1:0] fid_t;

    typedef struct packed {
        fid_t                  flow_id;
        logic [DATA_WIDTH-1:0] data;
    } slot_t;

    slot_t out_q, out_d;
    logic  out_valid_q, out_valid_d;
    slot_t ev_q, ev_d;
    logic  ev_valid_q, ev_valid_d;

    fid_t  rr_ptr;
    mode_e mode;
    logic  push_collides;
    logic  head_eligible;
    logic  slot_free;
    logic  pop;

    // A same-flow ingress push wins the bank port, so the reinsert waits.
    always_comb begin
        push_collides = i__bank_push_valid && (i__bank_push_flow_id == ev_q.flow_id);
        if (!ev_valid_q) begin
            mode = ModeScan;
        end else if (push_collides) begin
            mode = ModeBlocked;
        end else begin
            mode = ModeReinsert;
        end
    end

    always_comb begin
        head_eligible = 1'b0;
        for (int unsigned f = 0; f < NUM_FLOWS; f++) begin
            if (rr_ptr == IDX_WIDTH'(f)) begin
                head_eligible = i__flow_eligible[f];
            end
        end
    end

    // Slot frees in the same cycle it drains, giving one element per cycle.
    assign slot_free = !out_valid_q || i__out_ready;
    assign pop       = (mode == ModeScan) && i__pop_valid && head_eligible && slot_free;

    fifo_bank_drain_rr_ptr #(
        .NUM_FLOWS (NUM_FLOWS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr_ptr (
        .clk       (clk),
        .reset     (reset),
        .advance_i (mode == ModeScan),
        .ptr_o     (rr_ptr)
    );

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (pop) begin
            out_valid_d  = 1'b1;
            out_d.flow_id = rr_ptr;
            out_d.data    = i__pop_data;
        end else if (slot_free) begin
            out_valid_d = 1'b0;
        end
    end

    // Capture and reinsert are mutually exclusive: capture needs an empty buffer.
    always_comb begin
        ev_d       = ev_q;
        ev_valid_d = ev_valid_q;
        if (i__evict_valid && !ev_valid_q) begin
            ev_valid_d   = 1'b1;
            ev_d.flow_id = i__evict_flow_id;
            ev_d.data    = i__evict_data;
        end else if (mode == ModeReinsert) begin
            ev_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ev_q        <= '0;
            ev_valid_q  <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ev_q        <= ev_d;
            ev_valid_q  <= ev_valid_d;
        end
    end

    assign o__pop_flow_id    = (mode == ModeScan) ? rr_ptr : ev_q.flow_id;
    assign o__pop            = pop;
    assign o__reinsert_valid = (mode == ModeReinsert);
    assign o__reinsert_data  = ev_q.data;
    assign o__out_valid      = out_valid_q;
    assign o__out_flow_id    = out_q.flow_id;
    assign o__out_data       = out_q.data;
    assign o__evict_ready    = !ev_valid_q;

`ifdef FIFO_BANK_DRAIN_STATS_EN
    logic [31:0] stat_deq_q, stat_deq_d;
    logic [31:0] stat_rei_q, stat_rei_d;

    always_comb begin
        stat_deq_d = stat_deq_q;
        stat_rei_d = stat_rei_q;
        if (i__stat_clear) begin
            stat_deq_d = '0;
            stat_rei_d = '0;
        end else begin
            if (pop && (stat_deq_q != '1)) begin
                stat_deq_d = stat_deq_q + 32'd1;
            end
            if ((mode == ModeReinsert) && (stat_rei_q != '1)) begin
                stat_rei_d = stat_rei_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_deq_q <= '0;
            stat_rei_q <= '0;
        end else begin
            stat_deq_q <= stat_deq_d;
            stat_rei_q <= stat_rei_d;
        end
    end

    assign o__stat_dequeued   = stat_deq_q;
    assign o__stat_reinserted = stat_rei_q;
`endif

endmodule

// File: tb/tb_fifo_bank_drain.sv
// tb_fifo_bank_drain
// Directed bench for fifo_bank_drain with 4 flows. A small per-flow queue
// stands in for the FIFO bank: it answers the pop port combinationally and
// applies pops, ingress pushes and reinserts at each clock edge.

module tb_fifo_bank_drain;

    localparam int unsigned NF = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [IW-1:0] o__pop_flow_id;
    logic          o__pop;
    logic          i__pop_valid;
    logic [DW-1:0] i__pop_data;
    logic          o__reinsert_valid;
    logic [DW-1:0] o__reinsert_data;
    logic          i__bank_push_valid;
    logic [IW-1:0] i__bank_push_flow_id;
    logic [NF-1:0] i__flow_eligible;
    logic          o__out_valid;
    logic [IW-1:0] o__out_flow_id;
    logic [DW-1:0] o__out_data;
    logic          i__out_ready;
    logic          i__evict_valid;
    logic [IW-1:0] i__evict_flow_id;
    logic [DW-1:0] i__evict_data;
    logic          o__evict_ready;

    logic [DW-1:0] push_data;

    logic [DW-1:0] mem [8][8];
    int            cnt [8];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fifo_bank_drain #(
        .NUM_FLOWS  (NF),
        .DATA_WIDTH (DW)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .o__pop_flow_id       (o__pop_flow_id),
        .o__pop               (o__pop),
        .i__pop_valid         (i__pop_valid),
        .i__pop_data          (i__pop_data),
        .o__reinsert_valid    (o__reinsert_valid),
        .o__reinsert_data     (o__reinsert_data),
        .i__bank_push_valid   (i__bank_push_valid),
        .i__bank_push_flow_id (i__bank_push_flow_id),
        .i__flow_eligible     (i__flow_eligible),
        .o__out_valid         (o__out_valid),
        .o__out_flow_id       (o__out_flow_id),
        .o__out_data          (o__out_data),
        .i__out_ready         (i__out_ready),
        .i__evict_valid       (i__evict_valid),
        .i__evict_flow_id     (i__evict_flow_id),
        .i__evict_data        (i__evict_data),
        .o__evict_ready       (o__evict_ready)
    );

    typedef struct {
        logic          rdy;
        logic [NF-1:0] elig;
        logic          ld1;
        logic [IW-1:0] pfid;
        logic          pop;
        logic          ov;
        logic [IW-1:0] ofid;
        logic [DW-1:0] odata;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bank_append(input logic [IW-1:0] f, input logic [DW-1:0] d);
        if (cnt[f] < 8) begin
            mem[f][cnt[f]] = d;
            cnt[f]++;
        end
    endtask

    task automatic bank_clear();
        for (int f = 0; f < 8; f++) cnt[f] = 0;
    endtask

    // Drive inputs at the falling edge, then answer the pop port from the bank.
    task automatic drive(input logic rdy, input logic [NF-1:0] elig,
                         input logic pv, input logic [IW-1:0] pf, input logic [DW-1:0] pd,
                         input logic ev, input logic [IW-1:0] ef, input logic [DW-1:0] ed);
        logic [IW-1:0] f;
        i__out_ready         = rdy;
        i__flow_eligible     = elig;
        i__bank_push_valid   = pv;
        i__bank_push_flow_id = pf;
        push_data            = pd;
        i__evict_valid       = ev;
        i__evict_flow_id     = ef;
        i__evict_data        = ed;
        #1;
        f = o__pop_flow_id;
        if (cnt[f] > 0) begin
            i__pop_valid = 1'b1;
            i__pop_data  = mem[f][0];
        end else begin
            i__pop_valid = 1'b0;
            i__pop_data  = '0;
        end
        #1;
    endtask

    // Apply this cycle's bank operations, then move to the next falling edge.
    task automatic tick();
        logic [IW-1:0] f;
        f = o__pop_flow_id;
        if (o__pop && cnt[f] > 0) begin
            for (int k = 0; k < 7; k++) mem[f][k] = mem[f][k+1];
            cnt[f]--;
        end
        if (i__bank_push_valid) bank_append(i__bank_push_flow_id, push_data);
        if (o__reinsert_valid) bank_append(o__pop_flow_id, o__reinsert_data);
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        drive(rdy, 4'hF, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        bank_clear();
        reset                = 1'b1;
        i__pop_valid         = 1'b0;
        i__pop_data          = '0;
        i__bank_push_valid   = 1'b0;
        i__bank_push_flow_id = '0;
        push_data            = '0;
        i__flow_eligible     = '0;
        i__out_ready         = 1'b0;
        i__evict_valid       = 1'b0;
        i__evict_flow_id     = '0;
        i__evict_data        = '0;

        // rdy elig ld1 pfid pop ov ofid odata
        tbl[0]  = '{1'b1, 4'hF, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 8'h00};
        tbl[1]  = '{1'b1, 4'hF, 1'b0, 3'd1, 1'b0, 1'b1, 3'd0, 8'h11};
        tbl[2]  = '{1'b1, 4'hF, 1'b0, 3'd2, 1'b1, 1'b0, 3'd0, 8'h00};
        tbl[3]  = '{1'b1, 4'hF, 1'b0, 3'd3, 1'b0, 1'b1, 3'd2, 8'h22};
        tbl[4]  = '{1'b1, 4'hF, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00};
        tbl[5]  = '{1'b1, 4'hD, 1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 8'h00};
        tbl[6]  = '{1'b1, 4'hD, 1'b0, 3'd2, 1'b0, 1'b0, 3'd0, 8'h00};
        tbl[7]  = '{1'b1, 4'hD, 1'b0, 3'd3, 1'b0, 1'b0, 3'd0, 8'h00};
        tbl[8]  = '{1'b1, 4'hF, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00};
        tbl[9]  = '{1'b1, 4'hF, 1'b0, 3'd1, 1'b1, 1'b0, 3'd0, 8'h00};
        tbl[10] = '{1'b1, 4'hF, 1'b0, 3'd2, 1'b0, 1'b1, 3'd1, 8'h44};

        // Reset state
        #2;
        chk("rst_pop", 32'(o__pop), 0);
        chk("rst_pop_flow_id", 32'(o__pop_flow_id), 0);
        chk("rst_out_valid", 32'(o__out_valid), 0);
        chk("rst_evict_ready", 32'(o__evict_ready), 1);
        chk("rst_reinsert", 32'(o__reinsert_valid), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Round-robin scan and eligibility masking
        bank_append(3'd0, 8'h11);
        bank_append(3'd2, 8'h22);
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].ld1) bank_append(3'd1, 8'h44);
            drive(tbl[i].rdy, tbl[i].elig, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
            chk($sformatf("tbl%0d_pop_flow_id", i), 32'(o__pop_flow_id), 32'(tbl[i].pfid));
            chk($sformatf("tbl%0d_pop", i), 32'(o__pop), 32'(tbl[i].pop));
            chk($sformatf("tbl%0d_out_valid", i), 32'(o__out_valid), 32'(tbl[i].ov));
            if (tbl[i].ov) begin
                chk($sformatf("tbl%0d_out_flow_id", i), 32'(o__out_flow_id), 32'(tbl[i].ofid));
                chk($sformatf("tbl%0d_out_data", i), 32'(o__out_data), 32'(tbl[i].odata));
            end
            tick();
        end

        // Backpressure: hold the output, then drain and pop in the same cycle
        idle(1'b1); chk("bp_idle3_pop", 32'(o__pop), 0); tick();
        idle(1'b1); chk("bp_idle0_pop", 32'(o__pop), 0); tick();
        bank_append(3'd1, 8'h66);
        bank_append(3'd3, 8'h77);
        idle(1'b1);
        chk("bp_load_flow", 32'(o__pop_flow_id), 1);
        chk("bp_load_pop", 32'(o__pop), 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            chk($sformatf("bp_hold%0d_pop", i), 32'(o__pop), 0);
            chk($sformatf("bp_hold%0d_valid", i), 32'(o__out_valid), 1);
            chk($sformatf("bp_hold%0d_flow", i), 32'(o__out_flow_id), 1);
            chk($sformatf("bp_hold%0d_data", i), 32'(o__out_data), 32'h66);
            tick();
        end
        idle(1'b1);
        chk("bp_drain_flow", 32'(o__pop_flow_id), 3);
        chk("bp_drain_pop", 32'(o__pop), 1);
        chk("bp_drain_data", 32'(o__out_data), 32'h66);
        tick();
        idle(1'b1);
        chk("bp_next_valid", 32'(o__out_valid), 1);
        chk("bp_next_flow", 32'(o__out_flow_id), 3);
        chk("bp_next_data", 32'(o__out_data), 32'h77);
        tick();

        // Evict and reinsert (flow 2, 0x5A)
        drive(1'b1, 4'hF, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h5A);
        chk("ev_ready_before", 32'(o__evict_ready), 1);
        tick();
        i__evict_valid = 1'b0;
        idle(1'b1);
        chk("ev_ready_busy", 32'(o__evict_ready), 0);
        chk("ev_reinsert", 32'(o__reinsert_valid), 1);
        chk("ev_reinsert_flow", 32'(o__pop_flow_id), 2);
        chk("ev_reinsert_data", 32'(o__reinsert_data), 32'h5A);
        chk("ev_reinsert_pop", 32'(o__pop), 0);
        tick();
        idle(1'b1);
        chk("ev_ready_after", 32'(o__evict_ready), 1);
        chk("ev_rr_frozen", 32'(o__pop_flow_id), 2);
        chk("ev_pop_back", 32'(o__pop), 1);
        tick();
        idle(1'b1);
        chk("ev_out_flow", 32'(o__out_flow_id), 2);
        chk("ev_out_data", 32'(o__out_data), 32'h5A);
        tick();

        // Evict (flow 1, 0x33) blocked by three same-flow ingress pushes
        drive(1'b1, 4'hF, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 8'h33);
        chk("blk_ready_before", 32'(o__evict_ready), 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'hF, 1'b1, 3'd1, 8'hA1 + 8'(i), 1'b0, 3'd0, 8'h00);
            chk($sformatf("blk%0d_reinsert", i), 32'(o__reinsert_valid), 0);
            chk($sformatf("blk%0d_pop", i), 32'(o__pop), 0);
            chk($sformatf("blk%0d_flow", i), 32'(o__pop_flow_id), 1);
            chk($sformatf("blk%0d_ready", i), 32'(o__evict_ready), 0);
            tick();
        end
        idle(1'b1);
        chk("blk_reinsert", 32'(o__reinsert_valid), 1);
        chk("blk_reinsert_flow", 32'(o__pop_flow_id), 1);
        chk("blk_reinsert_data", 32'(o__reinsert_data), 32'h33);
        tick();
        chk("blk_bank_count", 32'(cnt[1]), 4);
        chk("blk_bank0", 32'(mem[1][0]), 32'hA1);
        chk("blk_bank1", 32'(mem[1][1]), 32'hA2);
        chk("blk_bank2", 32'(mem[1][2]), 32'hA3);
        chk("blk_bank3", 32'(mem[1][3]), 32'h33);
        idle(1'b1);
        chk("blk_pop_head", 32'(o__pop), 1);
        tick();

        // Reset while holding an output element and a buffered eviction
        drive(1'b0, 4'hF, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h99);
        chk("mid_out_valid", 32'(o__out_valid), 1);
        chk("mid_out_data", 32'(o__out_data), 32'hA1);
        tick();
        i__evict_valid = 1'b0;
        idle(1'b0);
        chk("mid_ev_busy", 32'(o__evict_ready), 0);
        reset = 1'b1;
        #1;
        chk("arst_out_valid", 32'(o__out_valid), 0);
        chk("arst_evict_ready", 32'(o__evict_ready), 1);
        chk("arst_pop", 32'(o__pop), 0);
        chk("arst_pop_flow_id", 32'(o__pop_flow_id), 0);
        chk("arst_reinsert", 32'(o__reinsert_valid), 0);
        bank_clear();
        @(negedge clk);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
